mutative_dfp_arbiter: RTL and testbench
=======================================

# mutative_dfp_arbiter

Shares the single downstream memory port (256-bit cacheline interface) between several mutative cache instances, such as instruction and data cache, each of which drives its own `dfp_*` port. The block grants one requester at a time, passes that requester's held read/write request to memory, and routes `mem_resp` back to the owner. It sits between the caches' `dfp_*` ports and the memory model/adapter.

## Interface
- `NUM_REQ`, default 2: number of cache requesters; legal range 2–8.
- `ADDR_WIDTH`, default 32: byte address width.
- `LINE_WIDTH`, default 256: cacheline width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_addr`  in  `[NUM_REQ][ADDR_WIDTH]`  per-requester line address; low 5 bits are 0.
- `req_read`  in  `[NUM_REQ]`  read request, held until that requester's `req_resp`.
- `req_write`  in  `[NUM_REQ]`  write request, held until that requester's `req_resp`.
- `req_wdata`  in  `[NUM_REQ][LINE_WIDTH]`  write line.
- `req_rdata`  out  `LINE_WIDTH`  `mem_rdata`, broadcast to all requesters.
- `req_resp`  out  `[NUM_REQ]`  one-hot completion pulse to the owner.
- `mem_addr`  out  `ADDR_WIDTH`  address to memory.
- `mem_read`  out  1  memory read.
- `mem_write`  out  1  memory write.
- `mem_wdata`  out  `LINE_WIDTH`  write line to memory.
- `mem_rdata`  in  `LINE_WIDTH`  read line from memory.
- `mem_resp`  in  1  memory completion, one cycle per transaction.

## Operation
- Two states, held in the shared enum `arb_state_t`:
  - `ARB_IDLE`: no transaction in progress.
  - `ARB_BUSY`: the registered `owner` index's transaction is in progress.
- Requester i is pending when `req_read[i] | req_write[i]`. Asserting both at once is illegal; the bench flags it with an assertion.
- In `ARB_IDLE`, if any requester is pending:
  - The picker selects a winner.
  - Next state is `ARB_BUSY` and `owner <= winner`.
  - If nothing is pending, the state stays `ARB_IDLE`.
- In `ARB_BUSY`:
  - `mem_addr`, `mem_read`, `mem_write` and `mem_wdata` equal `owner`'s inputs.
  - `req_resp[owner] = mem_resp`, combinationally.
  - On `mem_resp`, the next state is `ARB_IDLE` and the round-robin pointer becomes `owner+1`, wrapping from `NUM_REQ-1` to 0.
- In `ARB_IDLE`, all `mem_*` outputs and `req_resp` are 0.
- Requests are never preempted. A requester dropping its request while it is owner is illegal; the bench asserts on it.
- A cache write-back followed by a refill appears as two separate transactions. Another requester may be granted between them; this is allowed.
- `mem_resp` in `ARB_IDLE` is ignored and not forwarded.
- A new request arriving in the same cycle as `mem_resp` is arbitrated in the following `ARB_IDLE` cycle.

## Timing
- Reset values:
  - State `ARB_IDLE`, `owner` 0, round-robin pointer 0.
  - `mem_read`, `mem_write`, `req_resp` 0; `mem_addr`, `mem_wdata` 0.
  - `req_rdata` follows `mem_rdata` (combinational).
- Reset asserted mid-transaction:
  - Outputs drop the next cycle.
  - Any in-flight `mem_resp` is discarded.
  - Memory is reset in the same domain.
- Grant latency:
  - Request first visible in cycle N (in `ARB_IDLE`) → `mem_read`/`mem_write` high in cycle N+1.
  - Memory response in cycle M → `req_resp` in cycle M (zero-cycle pass-through).
  - State returns to `ARB_IDLE` in cycle M+1.
- Exactly one idle bubble separates consecutive transactions. Back-to-back throughput is (memory latency + 1) cycles per line.

## Configuration
- `MUTATIVE_DFP_ARB_RR_EN` defined: round-robin winner selection. The lowest-indexed pending requester at or above the pointer wins, wrapping past `NUM_REQ-1`.
- `MUTATIVE_DFP_ARB_RR_EN` undefined: fixed priority. The lowest-indexed pending requester always wins, and the pointer register is removed.

## Structure
- Additions to the `mutative_types` package:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_BUSY`).
  - `dfp_req_t` struct: addr, read, write, wdata.
  - `ARB_IDX_BITS = $clog2(NUM_REQ)`.
- Sub-module `mutative_arb_picker`: combinational. Inputs are the pending vector and the pointer; outputs are `winner` index and `any_pending`. It holds both selection policies under the macro.

## Test plan
- Port 0 read of 0x0000_1000, memory responds after 3 cycles with line L → `mem_read` high for 3 cycles, `req_resp` = 01 once, `req_rdata` = L, then idle.
- Ports 0 and 1 read continuously, RR enabled → grants alternate 0,1,0,1. Each `req_resp` is one-hot and one idle cycle separates each pair.
- Port 1 write of 0x0000_2000 (line W) followed by a read of 0x0000_3000 → `mem_write` with `mem_wdata` = W, `req_resp[1]`, one bubble, then `mem_read` at 0x3000.
- Macro undefined, both ports continuously pending → port 0 wins every arbitration and port 1 never receives `req_resp`.
- `rst` pulsed while port 1 is in `ARB_BUSY` → next cycle `mem_read`/`mem_write` are 0, state is `ARB_IDLE`, and the pointer is 0.
- `mem_resp` asserted while in `ARB_IDLE` → `req_resp` stays 0 and no state change occurs.

Source files
------------

// File: rtl/mutative_dfp_arbiter_pkg.sv
// Shared types for the mutative cache downstream-port arbiter: arbiter
// state encoding, a cacheline request bundle and index-width helpers.
package mutative_types;

    localparam int NUM_REQ_DEFAULT    = 2;
    localparam int ADDR_WIDTH_DEFAULT = 32;
    localparam int LINE_WIDTH_DEFAULT = 256;

    // Owner/pointer width for the default requester count.
    localparam int ARB_IDX_BITS = $clog2(NUM_REQ_DEFAULT);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // One requester's held cacheline request at the default widths.
    typedef struct packed {
        logic [ADDR_WIDTH_DEFAULT-1:0] addr;
        logic                          read;
        logic                          write;
        logic [LINE_WIDTH_DEFAULT-1:0] wdata;
    } dfp_req_t;

    // Index width for an arbitrary requester count (never below one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mutative_dfp_arbiter_if.sv
// Bundle of the per-requester dfp_* ports plus the single memory port.
// master: caches and memory model side; slave: the arbiter.
interface mutative_dfp_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]                 req_read;
    logic [NUM_REQ-1:0]                 req_write;
    logic [NUM_REQ-1:0][LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]              req_rdata;
    logic [NUM_REQ-1:0]                 req_resp;

    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic                               mem_read;
    logic                               mem_write;
    logic [LINE_WIDTH-1:0]              mem_wdata;
    logic [LINE_WIDTH-1:0]              mem_rdata;
    logic                               mem_resp;

    modport master (
        output req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
        input  req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

    modport slave (
        input  req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
        output req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/mutative_dfp_arbiter_picker.sv
// Combinational winner selection for the dfp arbiter.
// MUTATIVE_DFP_ARB_RR_EN defined: round-robin starting at ptr.
// MUTATIVE_DFP_ARB_RR_EN undefined: fixed priority, lowest index wins.
module mutative_arb_picker #(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [NUM_REQ-1:0]  pending,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [IDX_BITS-1:0] winner,
    output logic                any_pending
);

    logic [IDX_BITS-1:0] base;

`ifdef MUTATIVE_DFP_ARB_RR_EN
    assign base = ptr;
`else
    // Fixed priority is a scan that always starts at requester 0.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base       = '0;
`endif

    assign any_pending = |pending;

    // Scan from base upward with wrap; first pending requester wins.
    always_comb begin
        logic [IDX_BITS:0]   sum;
        logic [IDX_BITS-1:0] cand;
        logic                found;
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves one holding its old value (no latch).
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, base} + (IDX_BITS+1)'(k);
            if (sum >= (IDX_BITS+1)'(NUM_REQ)) begin
                sum = sum - (IDX_BITS+1)'(NUM_REQ);
            end
            cand = sum[IDX_BITS-1:0];
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mutative_dfp_arbiter.sv
// Shares one 256-bit cacheline memory port among NUM_REQ mutative caches.
// One transaction at a time, never preempted, one idle bubble between
// transactions. MUTATIVE_DFP_ARB_RR_EN selects round-robin over fixed
// priority and adds the round-robin pointer register.
module mutative_dfp_arbiter
    import mutative_types::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic                    clk,
    input logic                    rst,
    mutative_dfp_arbiter_if.slave  bus
);

    localparam int IDX_BITS = idx_bits(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [IDX_BITS-1:0] owner, owner_nxt;
    logic [IDX_BITS-1:0] ptr;
    logic [IDX_BITS-1:0] winner;
    logic                any_pending;
    logic [NUM_REQ-1:0]  pending;

    assign pending = bus.req_read | bus.req_write;

`ifdef MUTATIVE_DFP_ARB_RR_EN
    logic [IDX_BITS-1:0] rr_ptr, rr_ptr_nxt;

    // Pointer advances past the owner when its transaction completes.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (state == ARB_BUSY && bus.mem_resp) begin
            rr_ptr_nxt = (owner == IDX_BITS'(NUM_REQ - 1)) ? '0 : owner + IDX_BITS'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign ptr = rr_ptr;
`else
    assign ptr = '0;
`endif

    mutative_arb_picker #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_picker (
        .pending     (pending),
        .ptr         (ptr),
        .winner      (winner),
        .any_pending (any_pending)
    );

    // Next state: grant from idle, release on the memory response.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            ARB_IDLE: begin
                if (any_pending) begin
                    state_nxt = ARB_BUSY;
                    owner_nxt = winner;
                end
            end
            ARB_BUSY: begin
                if (bus.mem_resp) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State and owner registers, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state <= ARB_IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Memory port and completion routing; everything is quiet when idle.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = '0;
        bus.req_resp  = '0;
        if (state == ARB_BUSY) begin
            bus.mem_addr        = bus.req_addr[owner];
            bus.mem_read        = bus.req_read[owner];
            bus.mem_write       = bus.req_write[owner];
            bus.mem_wdata       = bus.req_wdata[owner];
            bus.req_resp[owner] = bus.mem_resp;
        end
    end

    assign bus.req_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mutative_dfp_arbiter.sv
// Directed bench for mutative_dfp_arbiter. Expectations follow the build:
// with MUTATIVE_DFP_ARB_RR_EN grants alternate, otherwise port 0 always wins.
module tb_mutative_dfp_arbiter;
    import mutative_types::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mutative_dfp_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    mutative_dfp_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [LW-1:0] line_l;
    logic [LW-1:0] line_w;
    logic [LW-1:0] line_r;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Illegal stimulus guards.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(|(bus.req_read & bus.req_write)))
                else $error("illegal: read and write asserted together");
            if (dut.state == ARB_BUSY) begin
                assert (bus.req_read[dut.owner] | bus.req_write[dut.owner])
                    else $error("illegal: owner dropped its request");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_resp;
        logic [AW-1:0] exp_addr;

        line_l = {8{32'hCAFE_0001}};
        line_w = {4{64'hDEAD_BEEF_0123_4567}};
        line_r = {16{16'h5A3C}};

        bus.req_addr  = '0;
        bus.req_read  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        bus.mem_rdata = line_r;
        settle();
        check("rst_mem_read",  LW'(bus.mem_read),  LW'(1'b0));
        check("rst_mem_write", LW'(bus.mem_write), LW'(1'b0));
        check("rst_req_resp",  LW'(bus.req_resp),  LW'(2'b00));
        check("rst_mem_addr",  LW'(bus.mem_addr),  LW'(32'h0));
        check("rst_mem_wdata", bus.mem_wdata,      LW'(1'b0));
        check("rst_rdata_fwd", bus.req_rdata,      line_r);
        check("rst_state",     LW'(dut.state),     LW'(ARB_IDLE));
        check("rst_owner",     LW'(dut.owner),     LW'(1'b0));
`ifdef MUTATIVE_DFP_ARB_RR_EN
        check("rst_ptr",       LW'(dut.rr_ptr),    LW'(1'b0));
`endif

        // Port 0 read of 0x1000, memory answers in the third busy cycle
        bus.req_read[0] = 1'b1;
        bus.req_addr[0] = 32'h0000_1000;
        settle();
        check("t1_idle_read", LW'(bus.mem_read), LW'(1'b0));
        cyc();
        check("t1_b1_read", LW'(bus.mem_read), LW'(1'b1));
        check("t1_b1_addr", LW'(bus.mem_addr), LW'(32'h0000_1000));
        check("t1_b1_resp", LW'(bus.req_resp), LW'(2'b00));
        cyc();
        check("t1_b2_read", LW'(bus.mem_read), LW'(1'b1));
        check("t1_b2_resp", LW'(bus.req_resp), LW'(2'b00));
        cyc();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = line_l;
        settle();
        check("t1_b3_read",  LW'(bus.mem_read), LW'(1'b1));
        check("t1_b3_resp",  LW'(bus.req_resp), LW'(2'b01));
        check("t1_b3_rdata", bus.req_rdata,     line_l);
        cyc();
        bus.mem_resp    = 1'b0;
        bus.req_read[0] = 1'b0;
        settle();
        check("t1_done_read", LW'(bus.mem_read), LW'(1'b0));
        check("t1_done_resp", LW'(bus.req_resp), LW'(2'b00));
        cyc();
        check("t1_idle2_read", LW'(bus.mem_read), LW'(1'b0));
`ifdef MUTATIVE_DFP_ARB_RR_EN
        check("t1_ptr", LW'(dut.rr_ptr), LW'(1'b1));
`endif

        // Reset while port 1 owns the memory port; late mem_resp discarded
        bus.req_read[1] = 1'b1;
        bus.req_addr[1] = 32'h0000_6000;
        settle();
        cyc();
        check("rb_busy_read", LW'(bus.mem_read), LW'(1'b1));
        check("rb_busy_addr", LW'(bus.mem_addr), LW'(32'h0000_6000));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_read[1] = 1'b0;
        bus.mem_resp    = 1'b1;
        settle();
        check("rb_read",  LW'(bus.mem_read),  LW'(1'b0));
        check("rb_write", LW'(bus.mem_write), LW'(1'b0));
        check("rb_resp",  LW'(bus.req_resp),  LW'(2'b00));
        check("rb_state", LW'(dut.state),     LW'(ARB_IDLE));
`ifdef MUTATIVE_DFP_ARB_RR_EN
        check("rb_ptr",   LW'(dut.rr_ptr),    LW'(1'b0));
`endif
        cyc();
        bus.mem_resp = 1'b0;
        settle();
        check("rb_after_state", LW'(dut.state), LW'(ARB_IDLE));

        // Port 1 write-back of 0x2000 then refill of 0x3000
        bus.req_write[1] = 1'b1;
        bus.req_addr[1]  = 32'h0000_2000;
        bus.req_wdata[1] = line_w;
        settle();
        check("wr_idle_write", LW'(bus.mem_write), LW'(1'b0));
        cyc();
        bus.mem_resp = 1'b1;
        settle();
        check("wr_write", LW'(bus.mem_write), LW'(1'b1));
        check("wr_read",  LW'(bus.mem_read),  LW'(1'b0));
        check("wr_addr",  LW'(bus.mem_addr),  LW'(32'h0000_2000));
        check("wr_wdata", bus.mem_wdata,      line_w);
        check("wr_resp",  LW'(bus.req_resp),  LW'(2'b10));
        cyc();
        bus.mem_resp     = 1'b0;
        bus.req_write[1] = 1'b0;
        bus.req_read[1]  = 1'b1;
        bus.req_addr[1]  = 32'h0000_3000;
        settle();
        check("wr_bubble_read",  LW'(bus.mem_read),  LW'(1'b0));
        check("wr_bubble_write", LW'(bus.mem_write), LW'(1'b0));
        cyc();
        bus.mem_rdata = line_r;
        bus.mem_resp  = 1'b1;
        settle();
        check("rd_read",  LW'(bus.mem_read),  LW'(1'b1));
        check("rd_addr",  LW'(bus.mem_addr),  LW'(32'h0000_3000));
        check("rd_resp",  LW'(bus.req_resp),  LW'(2'b10));
        check("rd_rdata", bus.req_rdata,      line_r);
        cyc();
        bus.mem_resp    = 1'b0;
        bus.req_read[1] = 1'b0;
        settle();
        check("rd_done_read", LW'(bus.mem_read), LW'(1'b0));

        // Both ports continuously pending
        bus.req_addr[0] = 32'h0000_4000;
        bus.req_addr[1] = 32'h0000_5000;
        bus.req_read    = 2'b11;
        for (int t = 0; t < 4; t++) begin
`ifdef MUTATIVE_DFP_ARB_RR_EN
            exp_resp = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000;
`else
            exp_resp = 2'b01;
            exp_addr = 32'h0000_4000;
`endif
            settle();
            check($sformatf("arb%0d_bubble_read", t), LW'(bus.mem_read), LW'(1'b0));
            check($sformatf("arb%0d_bubble_resp", t), LW'(bus.req_resp), LW'(2'b00));
            cyc();
            bus.mem_resp = 1'b1;
            settle();
            check($sformatf("arb%0d_addr", t), LW'(bus.mem_addr), LW'(exp_addr));
            check($sformatf("arb%0d_resp", t), LW'(bus.req_resp), LW'(exp_resp));
            cyc();
            bus.mem_resp = 1'b0;
        end
        bus.req_read = 2'b00;
        settle();
        check("arb_end_read", LW'(bus.mem_read), LW'(1'b0));

        // mem_resp while idle is ignored
        cyc();
        bus.mem_resp = 1'b1;
        settle();
        check("idle_resp_fwd",  LW'(bus.req_resp), LW'(2'b00));
        check("idle_resp_read", LW'(bus.mem_read), LW'(1'b0));
        cyc();
        bus.mem_resp = 1'b0;
        settle();
        check("idle_resp_state", LW'(dut.state), LW'(ARB_IDLE));
`ifdef MUTATIVE_DFP_ARB_RR_EN
        check("idle_resp_ptr",   LW'(dut.rr_ptr), LW'(1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
